// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: push/pop request and RAM port bundle for fifo_ctrl.
// Optional feature macro: FIFO_CTRL_ERR_EN (adds sticky overflow/underflow).
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  rd;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
`ifdef FIFO_CTRL_ERR_EN
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop,
        input  w_addr, wr, r_addr, rd, rd_valid, full, empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  push, pop,
        output w_addr, wr, r_addr, rd, rd_valid, full, empty,
               almost_full, almost_empty, count, overflow, underflow
    );
`else
    modport master (
        output push, pop,
        input  w_addr, wr, r_addr, rd, rd_valid, full, empty,
               almost_full, almost_empty, count
    );

    modport slave (
        input  push, pop,
        output w_addr, wr, r_addr, rd, rd_valid, full, empty,
               almost_full, almost_empty, count
    );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: turns an 8-bit dual-port RAM into a 2^ADDR_WIDTH-entry FIFO.
// Wrap-bit pointers give occupancy and flags; rd_valid is rd delayed by one.
// Optional feature macro: FIFO_CTRL_ERR_EN (sticky overflow/underflow flags).
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = 240,
    parameter int AE_LEVEL   = 16
) (
    input logic        clk,
    input logic        reset,
    fifo_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] AF_THR = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_THR = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH:0] count_w;
    logic                full_w, empty_w, wr_w, rd_w;

    // Status flags and request acceptance from registered pointers.
    always_comb begin
        count_w = wptr_q - rptr_q;
        empty_w = (wptr_q == rptr_q);
        full_w  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                  (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
        wr_w    = bus.push & ~full_w;
        rd_w    = bus.pop & ~empty_w;
    end

    // Next-state pointers and read-valid pipeline.
    always_comb begin
        wptr_d     = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_w};
        rptr_d     = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_w};
        rd_valid_d = rd_w;
    end

    // Pointer and rd_valid registers; reset discards contents and any pending read.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.w_addr       = wptr_q[ADDR_WIDTH-1:0];
    assign bus.r_addr       = rptr_q[ADDR_WIDTH-1:0];
    assign bus.wr           = wr_w;
    assign bus.rd           = rd_w;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.count        = count_w;
    assign bus.almost_full  = (count_w >= AF_THR);
    assign bus.almost_empty = (count_w <= AE_THR);

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: any request arriving against a full/empty FIFO.
    always_comb begin
        overflow_d  = overflow_q | (bus.push & full_w);
        underflow_d = underflow_q | (bus.pop & empty_w);
    end

    // Error flag registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule
